// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - lookup and training bus of the branch target buffer
interface branch_predictor_btb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // fetch-side lookup
    logic [DATA_WIDTH-1:0] PC;
    logic                  predict_taken;
    logic [DATA_WIDTH-1:0] branch_target;
    // execute-side resolution
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_PC;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    // performance counter
    logic [CNT_WIDTH-1:0]  mispredict_cnt;

    modport master (
        output PC, upd_valid, upd_PC, upd_taken, upd_target, upd_mispredict,
        input  predict_taken, branch_target, mispredict_cnt
    );

    modport slave (
        input  PC, upd_valid, upd_PC, upd_taken, upd_target, upd_mispredict,
        output predict_taken, branch_target, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer with 2-bit saturating counters
module branch_predictor_btb #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0]    r_valid;
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];
    logic [CNT_WIDTH-1:0]  r_mis_cnt;

    logic [IDX_W-1:0]      w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_taken;
    logic [IDX_W-1:0]      w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic [1:0]            w_up_ctr;
    logic [1:0]            w_ctr_inc;
    logic [1:0]            w_ctr_dec;

    // PC[1:0] never selects an entry; instructions are word aligned
    assign w_lk_idx = bus.PC[IDX_W+1:2];
    assign w_lk_tag = bus.PC[DATA_WIDTH-1:IDX_W+2];
    assign w_up_idx = bus.upd_PC[IDX_W+1:2];
    assign w_up_tag = bus.upd_PC[DATA_WIDTH-1:IDX_W+2];

    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = !rst && w_lk_hit && r_ctr[w_lk_idx][1];

    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr  = r_ctr[w_up_idx];
    assign w_ctr_inc = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'b01;
    assign w_ctr_dec = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'b01;

    // lookup reads registered state only, so a same-cycle update is seen next cycle
    assign bus.predict_taken  = w_lk_taken;
    assign bus.branch_target  = w_lk_taken ? r_target[w_lk_idx] : '0;
    assign bus.mispredict_cnt = r_mis_cnt;

    // valid bits and direction counters; reset empties the table and wins over training
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= bus.upd_taken ? w_ctr_inc : w_ctr_dec;
            end else if (bus.upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    // tag and target storage; only taken resolutions write, so not-taken never evicts
    always_ff @(posedge clk) begin
        if (!rst && bus.upd_valid && bus.upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bus.upd_target;
        end
    end

    // mispredict counter saturates at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis_cnt <= '0;
        end else if (bus.upd_valid && bus.upd_mispredict && (r_mis_cnt != '1)) begin
            r_mis_cnt <= r_mis_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
module tb_branch_predictor_btb;
    logic clk;
    logic rst;

    branch_predictor_btb_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) bus ();

    branch_predictor_btb #(
        .DATA_WIDTH(32),
        .ENTRIES   (16),
        .CNT_WIDTH (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] tgt;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one cycle of stimulus and queue the outputs expected during that cycle
    task automatic cyc(input string name, input logic r, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um,
                       input logic ep, input logic [31:0] et, input logic [1:0] ec);
        exp_t e;
        rst                = r;
        bus.PC             = pc;
        bus.upd_valid      = uv;
        bus.upd_PC         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utgt;
        bus.upd_mispredict = um;
        e.name = name;
        e.pt   = ep;
        e.tgt  = et;
        e.cnt  = ec;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // monitor: compare whatever the DUT presents mid-cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.predict_taken !== e.pt) begin
                n_bad++;
                $display("FAIL %s predict_taken got %0b want %0b", e.name, bus.predict_taken, e.pt);
            end
            n_cmp++;
            if (bus.branch_target !== e.tgt) begin
                n_bad++;
                $display("FAIL %s branch_target got 0x%0h want 0x%0h", e.name, bus.branch_target, e.tgt);
            end
            n_cmp++;
            if (bus.mispredict_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL %s mispredict_cnt got %0d want %0d", e.name, bus.mispredict_cnt, e.cnt);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst                = 1'b1;
        bus.PC             = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_PC         = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = '0;
        bus.upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //   name          rst pc     uv upc    ut utgt   um  pt tgt    cnt
        // reset and empty table
        cyc("rst_hold",    1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        cyc("empty",       0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        // allocate on taken miss; same-cycle lookup sees old contents
        cyc("alloc_same",  0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 0, 32'h0,   2'd0);
        cyc("alloc_next",  0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  2'd0);
        // train up to saturation then back down
        cyc("tk1",         0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 1, 32'h40,  2'd0);
        cyc("tk2",         0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 1, 32'h40,  2'd0);
        cyc("tk3",         0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 1, 32'h40,  2'd0);
        cyc("nt1",         0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 32'h40,  2'd0);
        cyc("after_nt1",   0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  2'd0);
        cyc("nt2",         0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 32'h40,  2'd0);
        cyc("after_nt2",   0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        // aliasing at index 0: 0x140 evicts 0x100, 0x180 not-taken leaves it alone
        cyc("retrain",     0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 0, 32'h0,   2'd0);
        cyc("evict",       0, 32'h100, 1, 32'h140, 1, 32'h80,  0, 1, 32'h40,  2'd0);
        cyc("old_miss",    0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        cyc("new_hit",     0, 32'h140, 1, 32'h180, 0, 32'h0,   0, 1, 32'h80,  2'd0);
        cyc("nt_no_evict", 0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 32'h80,  2'd0);
        cyc("alias_miss",  0, 32'h180, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        // taken hit replaces target; low PC bits ignored; another index
        cyc("retarget",    0, 32'h140, 1, 32'h140, 1, 32'h200, 0, 1, 32'h80,  2'd0);
        cyc("low_bits",    0, 32'h142, 1, 32'h104, 1, 32'h300, 0, 1, 32'h200, 2'd0);
        cyc("idx1_hit",    0, 32'h104, 1, 32'h104, 0, 32'h0,   0, 1, 32'h300, 2'd0);
        cyc("idx1_drop",   0, 32'h104, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        cyc("idx0_kept",   0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 2'd0);
        // mispredict counter: unqualified strobe ignored, then saturate at 3
        cyc("mis_novalid", 0, 32'h140, 0, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd0);
        cyc("mis1",        0, 32'h140, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd0);
        cyc("mis2",        0, 32'h140, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd1);
        cyc("mis3",        0, 32'h140, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd2);
        cyc("mis4",        0, 32'h140, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd3);
        cyc("mis5",        0, 32'h140, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 2'd3);
        cyc("mis_sat",     0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 2'd3);
        // reset beats a concurrent update
        cyc("rst_upd",     1, 32'h140, 1, 32'h100, 1, 32'h40,  1, 0, 32'h0,   2'd3);
        cyc("post_rst_a",  0, 32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        cyc("post_rst_b",  0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);
        cyc("post_rst_c",  0, 32'h104, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   2'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
